// File: rtl/window_filter_ctrl.sv
// window_filter_ctrl: sweeps every full 3x3 window of an IMG_W x IMG_H image,
// smooths it with a 1-2-1 / 2-4-2 / 1-2-1 kernel and writes the result at the
// window centre. A valid/address tag pipeline travels alongside each read so
// that writes line up with the data coming back from the window memory.
module window_filter_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd,
  output logic [7:0] addr_row_r,
  output logic [7:0] addr_col_r,
  input  logic [7:0] sw_pixel_1,
  input  logic [7:0] sw_pixel_2,
  input  logic [7:0] sw_pixel_3,
  input  logic [7:0] sw_pixel_4,
  input  logic [7:0] sw_pixel_5,
  input  logic [7:0] sw_pixel_6,
  input  logic [7:0] sw_pixel_7,
  input  logic [7:0] sw_pixel_8,
  input  logic [7:0] sw_pixel_9,
  output logic       wr,
  output logic [7:0] addr_row_w,
  output logic [7:0] addr_col_w,
  output logic [7:0] cl_pixel
);

  // Tag depth: RD_LAT for the memory, plus the two filter stages.
  localparam int DEPTH = RD_LAT + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] COL_LAST   = 8'(IMG_W - 3);
  localparam logic [7:0] ROW_LAST   = 8'(IMG_H - 3);
  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT + 1);
  // Number of DRAIN cycles that keep rd high to flush the final window.
  localparam logic [2:0] DRAIN_RD   = 3'(RD_LAT - 1);

  logic [1:0] state_reg;
  logic [7:0] row_reg;
  logic [7:0] col_reg;
  logic       rd_reg;
  logic [2:0] drain_cnt_reg;

  logic       issue_valid;
  logic [9:0] corner_reg;
  logic [9:0] edge_reg;
  logic [7:0] centre_reg;
  logic [11:0] s_next;
  logic [7:0] cl_next;
  logic [7:0] row_w_reg;
  logic [7:0] col_w_reg;
  logic [7:0] cl_reg;

  // Only reads issued during SCAN carry a valid tag; DRAIN flush reads do not.
  assign issue_valid = (state_reg == ST_SCAN);

  // Control FSM: window sweep (column first), drain, one-cycle done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      row_reg       <= 8'd0;
      col_reg       <= 8'd0;
      rd_reg        <= 1'b0;
      drain_cnt_reg <= 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_SCAN;
            row_reg   <= 8'd0;
            col_reg   <= 8'd0;
            rd_reg    <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (row_reg == ROW_LAST && col_reg == COL_LAST) begin
            // Address stays on the final window for the flush reads.
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= 3'd0;
            rd_reg        <= (DRAIN_RD != 3'd0);
          end else if (col_reg == COL_LAST) begin
            col_reg <= 8'd0;
            row_reg <= row_reg + 8'd1;
          end else begin
            col_reg <= col_reg + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg <= ST_DONE;
            rd_reg    <= 1'b0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 3'd1;
            rd_reg        <= ((drain_cnt_reg + 3'd1) < DRAIN_RD);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Valid-tag shift register, one flop per cycle of read-to-write latency.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_vld
      logic v_q;
      if (gi == 0) begin : g_head
        // First tag stage captures the read issued this cycle.
        always_ff @(posedge clk) begin
          if (!rst) v_q <= 1'b0;
          else      v_q <= issue_valid;
        end
      end else begin : g_body
        // Later tag stages simply shift.
        always_ff @(posedge clk) begin
          if (!rst) v_q <= 1'b0;
          else      v_q <= g_vld[gi-1].v_q;
        end
      end
    end

    // Window address only needs to travel as far as the second filter stage.
    for (gi = 0; gi <= RD_LAT; gi++) begin : g_adr
      logic [7:0] r_q;
      logic [7:0] c_q;
      if (gi == 0) begin : g_head
        // First address stage captures the window being read.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_q <= 8'd0;
            c_q <= 8'd0;
          end else begin
            r_q <= row_reg;
            c_q <= col_reg;
          end
        end
      end else begin : g_body
        // Later address stages simply shift.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_q <= 8'd0;
            c_q <= 8'd0;
          end else begin
            r_q <= g_adr[gi-1].r_q;
            c_q <= g_adr[gi-1].c_q;
          end
        end
      end
    end
  endgenerate

  // Filter stage 1: group the window into corner, edge and centre terms.
  always_ff @(posedge clk) begin
    if (!rst) begin
      corner_reg <= 10'd0;
      edge_reg   <= 10'd0;
      centre_reg <= 8'd0;
    end else if (g_vld[RD_LAT-1].v_q) begin
      corner_reg <= {2'b00, sw_pixel_1} + {2'b00, sw_pixel_3}
                  + {2'b00, sw_pixel_7} + {2'b00, sw_pixel_9};
      edge_reg   <= {2'b00, sw_pixel_2} + {2'b00, sw_pixel_4}
                  + {2'b00, sw_pixel_6} + {2'b00, sw_pixel_8};
      centre_reg <= sw_pixel_5;
    end
  end

  // Weighted sum peaks at 16*255 = 4080, so 12 bits and no saturation.
  assign s_next  = {2'b00, corner_reg} + {1'b0, edge_reg, 1'b0} + {2'b00, centre_reg, 2'b00};
  assign cl_next = 8'((s_next + 12'd8) >> 4);

  // Filter stage 2: round-half-up result and centre write address; held when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_w_reg <= 8'd0;
      col_w_reg <= 8'd0;
      cl_reg    <= 8'd0;
    end else if (g_vld[RD_LAT].v_q) begin
      row_w_reg <= g_adr[RD_LAT].r_q + 8'd1;
      col_w_reg <= g_adr[RD_LAT].c_q + 8'd1;
      cl_reg    <= cl_next;
    end
  end

  assign busy       = (state_reg == ST_SCAN) || (state_reg == ST_DRAIN);
  assign done       = (state_reg == ST_DONE);
  assign rd         = rd_reg;
  assign addr_row_r = row_reg;
  assign addr_col_r = col_reg;
  assign wr         = g_vld[DEPTH-1].v_q;
  assign addr_row_w = row_w_reg;
  assign addr_col_w = col_w_reg;
  assign cl_pixel   = cl_reg;

endmodule

// File: tb/tb_window_filter_ctrl.sv
// tb_window_filter_ctrl: three instances (256x256 constant image, 5x4 timing
// frame, 20x20 impulse with RD_LAT=3) each fed by a behavioural window memory.
module tb_window_filter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- big instance: 256x256, RD_LAT=2, constant 100 ----------
  logic       b_rst, b_start, b_busy, b_done, b_rd, b_wr;
  logic [7:0] b_arr, b_acr, b_arw, b_acw, b_cl;
  logic [7:0] b_p [9];
  logic [7:0] b_dr [2];
  logic [7:0] b_dc [2];

  // ---------------- small instance: 5x4, RD_LAT=2 ---------------------------
  logic       s_rst, s_start, s_busy, s_done, s_rd, s_wr;
  logic [7:0] s_arr, s_acr, s_arw, s_acw, s_cl;
  logic [7:0] s_p [9];
  logic [7:0] s_dr [2];
  logic [7:0] s_dc [2];
  int         s_mode = 0;

  // ---------------- impulse instance: 20x20, RD_LAT=3 -----------------------
  logic       i_rst, i_start, i_busy, i_done, i_rd, i_wr;
  logic [7:0] i_arr, i_acr, i_arw, i_acw, i_cl;
  logic [7:0] i_p [9];
  logic [7:0] i_dr [3];
  logic [7:0] i_dc [3];

  window_filter_ctrl #(.IMG_W(256), .IMG_H(256), .RD_LAT(2)) u_big (
    .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd(b_rd), .addr_row_r(b_arr), .addr_col_r(b_acr),
    .sw_pixel_1(b_p[0]), .sw_pixel_2(b_p[1]), .sw_pixel_3(b_p[2]),
    .sw_pixel_4(b_p[3]), .sw_pixel_5(b_p[4]), .sw_pixel_6(b_p[5]),
    .sw_pixel_7(b_p[6]), .sw_pixel_8(b_p[7]), .sw_pixel_9(b_p[8]),
    .wr(b_wr), .addr_row_w(b_arw), .addr_col_w(b_acw), .cl_pixel(b_cl));

  window_filter_ctrl #(.IMG_W(5), .IMG_H(4), .RD_LAT(2)) u_sm (
    .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd(s_rd), .addr_row_r(s_arr), .addr_col_r(s_acr),
    .sw_pixel_1(s_p[0]), .sw_pixel_2(s_p[1]), .sw_pixel_3(s_p[2]),
    .sw_pixel_4(s_p[3]), .sw_pixel_5(s_p[4]), .sw_pixel_6(s_p[5]),
    .sw_pixel_7(s_p[6]), .sw_pixel_8(s_p[7]), .sw_pixel_9(s_p[8]),
    .wr(s_wr), .addr_row_w(s_arw), .addr_col_w(s_acw), .cl_pixel(s_cl));

  window_filter_ctrl #(.IMG_W(20), .IMG_H(20), .RD_LAT(3)) u_imp (
    .clk(clk), .rst(i_rst), .start(i_start), .busy(i_busy), .done(i_done),
    .rd(i_rd), .addr_row_r(i_arr), .addr_col_r(i_acr),
    .sw_pixel_1(i_p[0]), .sw_pixel_2(i_p[1]), .sw_pixel_3(i_p[2]),
    .sw_pixel_4(i_p[3]), .sw_pixel_5(i_p[4]), .sw_pixel_6(i_p[5]),
    .sw_pixel_7(i_p[6]), .sw_pixel_8(i_p[7]), .sw_pixel_9(i_p[8]),
    .wr(i_wr), .addr_row_w(i_arw), .addr_col_w(i_acw), .cl_pixel(i_cl));

  // Source images.
  function automatic int pix_s(input int mode, input int r, input int c);
    if (mode == 1) return 255;
    return (r * 37 + c * c * 11 + r * c * 5) & 255;
  endfunction

  function automatic int pix_i(input int r, input int c);
    return (r == 10 && c == 10) ? 255 : 0;
  endfunction

  // Reference smoothing of the window whose top-left is (r,c), small image.
  function automatic int kern_s(input int mode, input int r, input int c);
    int sum;
    sum = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        sum += ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1) * pix_s(mode, r + dr, c + dc);
    return (sum + 8) >> 4;
  endfunction

  // Hand values for the impulse at (10,10): centre 64, edge 32, corner 16.
  function automatic int imp_exp(input int wr_row, input int wr_col);
    int dr, dc;
    dr = wr_row - 10;
    dc = wr_col - 10;
    if (dr < -1 || dr > 1 || dc < -1 || dc > 1) return 0;
    if (dr == 0 && dc == 0) return 64;
    if (dr == 0 || dc == 0) return 32;
    return 16;
  endfunction

  // Behavioural window memories: registered address delay of RD_LAT cycles.
  always @(posedge clk) begin
    b_dr[0] <= b_arr; b_dc[0] <= b_acr; b_dr[1] <= b_dr[0]; b_dc[1] <= b_dc[0];
    s_dr[0] <= s_arr; s_dc[0] <= s_acr; s_dr[1] <= s_dr[0]; s_dc[1] <= s_dc[0];
    i_dr[0] <= i_arr; i_dc[0] <= i_acr; i_dr[1] <= i_dr[0]; i_dc[1] <= i_dc[0];
    i_dr[2] <= i_dr[1]; i_dc[2] <= i_dc[1];
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      b_p[i] = 8'd100;
      s_p[i] = 8'(pix_s(s_mode, int'(s_dr[1]) + i / 3, int'(s_dc[1]) + i % 3));
      i_p[i] = 8'(pix_i(int'(i_dr[2]) + i / 3, int'(i_dc[2]) + i % 3));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Write scoreboards: index of the next expected write per instance.
  int b_idx = 0, s_idx = 0, i_idx = 0;
  int b_last = -1, s_last = -1, i_last = -1;
  logic b_pw = 1'b0, s_pw = 1'b0, i_pw = 1'b0;

  // Advance one cycle; sample at the falling edge and score every write.
  task automatic tick();
    int er, ec, ev;
    @(negedge clk);
    // big
    if (b_done) begin check("b_done_after_wr", int'(b_pw), 1); b_last = b_idx; end
    if (b_wr) begin
      er = b_idx / 254 + 1; ec = b_idx % 254 + 1;
      check("b_wr", int'({b_arw, b_acw, b_cl}), (er << 16) | (ec << 8) | 100);
      check("b_wr_busy", int'(b_busy), 1);
      b_idx++;
    end
    if (!b_busy) b_idx = 0;
    b_pw = b_wr;
    // small
    if (s_done) begin check("s_done_after_wr", int'(s_pw), 1); s_last = s_idx; end
    if (s_wr) begin
      er = s_idx / 3 + 1; ec = s_idx % 3 + 1;
      ev = (s_mode == 1) ? 255 : kern_s(s_mode, er - 1, ec - 1);
      $display("sm wr row=%0d col=%0d pix=%0d exp=%0d", s_arw, s_acw, s_cl, ev);
      check("s_wr", int'({s_arw, s_acw, s_cl}), (er << 16) | (ec << 8) | ev);
      check("s_wr_busy", int'(s_busy), 1);
      s_idx++;
    end
    if (!s_busy) s_idx = 0;
    s_pw = s_wr;
    // impulse
    if (i_done) begin check("i_done_after_wr", int'(i_pw), 1); i_last = i_idx; end
    if (i_wr) begin
      er = i_idx / 18 + 1; ec = i_idx % 18 + 1;
      ev = imp_exp(er, ec);
      if (ev != 0) $display("imp wr row=%0d col=%0d pix=%0d exp=%0d", i_arw, i_acw, i_cl, ev);
      check("i_wr", int'({i_arw, i_acw, i_cl}), (er << 16) | (ec << 8) | ev);
      i_idx++;
    end
    if (!i_busy) i_idx = 0;
    i_pw = i_wr;
  endtask

  // Small-frame cycle table, index = cycle after start sampled; {busy,done,rd,wr}.
  int exp_ctl [13] = '{0, 10, 10, 10, 10, 11, 11, 11, 9, 9, 9, 4, 0};
  int rtab [8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
  int ctab [8]  = '{0, 0, 1, 2, 0, 1, 2, 2};
  int wrow [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2};
  int wcol [11] = '{0, 0, 0, 0, 0, 1, 2, 3, 1, 2, 3};

  // One small-frame pass; optional start pulses in SCAN, DRAIN and DONE.
  task automatic run_sm(input bit ign);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      check("s_ctl", int'({s_busy, s_done, s_rd, s_wr}), exp_ctl[c]);
      if (c <= 7) check("s_raddr", int'({s_arr, s_acr}), (rtab[c] << 8) | ctab[c]);
      if (c >= 5 && c <= 10) check("s_waddr", int'({s_arw, s_acw}), (wrow[c] << 8) | wcol[c]);
      s_start = (ign && (c == 2 || c == 8 || c == 11)) ? 1'b1 : 1'b0;
    end
    s_start = 1'b0;
    check("s_count", s_last, 6);
  endtask

  initial begin
    int n;
    b_rst = 1'b0; s_rst = 1'b0; i_rst = 1'b0;
    b_start = 1'b0; s_start = 1'b0; i_start = 1'b0;
    repeat (3) tick();
    check("rst_sm", int'({s_busy, s_done, s_rd, s_wr, s_arr, s_acr, s_arw, s_acw, s_cl}), 0);
    check("rst_big", int'({b_busy, b_done, b_rd, b_wr, b_arr, b_acr, b_arw, b_acw, b_cl}), 0);
    check("rst_imp", int'({i_busy, i_done, i_rd, i_wr, i_arr, i_acr, i_arw, i_acw, i_cl}), 0);
    b_rst = 1'b1; s_rst = 1'b1; i_rst = 1'b1;
    tick();

    // Small-frame timing with a non-uniform image.
    run_sm(1'b0);

    // All-255 image: no overflow, every write 255.
    s_mode = 1;
    run_sm(1'b0);
    check("s_cl_255", int'(s_cl), 255);
    s_mode = 0;

    // Reset in the middle of SCAN after three writes.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (s_idx < 3 && n < 20) begin tick(); n++; end
    check("s_three_writes", s_idx, 3);
    s_rst = 1'b0;
    tick();
    check("rst_mid", int'({s_busy, s_done, s_rd, s_wr, s_arr, s_acr, s_arw, s_acw, s_cl}), 0);
    s_rst = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_wr || s_busy || s_done) n++;
    end
    check("rst_quiet", n, 0);
    run_sm(1'b0);

    // Extra start pulses outside IDLE are ignored.
    run_sm(1'b1);

    // Impulse image on a 20x20 frame with RD_LAT=3.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!i_done && n < 500) begin tick(); n++; end
    check("i_done_seen", int'(i_done), 1);
    check("i_count", i_last, 324);
    tick();
    check("i_idle", int'({i_busy, i_done}), 0);

    // Full default-size frame, constant 100.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 70000) begin tick(); n++; end
    check("b_done_seen", int'(b_done), 1);
    check("b_busy_at_done", int'(b_busy), 0);
    check("b_count", b_last, 64516);
    check("b_last_addr", int'({b_arw, b_acw}), (254 << 8) | 254);
    $display("big pass writes=%0d", b_last);
    tick();
    check("b_idle", int'({b_busy, b_done, b_wr}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_filter_ctrl.md
Name: window_filter_ctrl

Overview:
- Sits beside the 3x3 window memory and drives both its ports.
- Sweeps the read address over every full 3x3 window of the source image and consumes the nine window pixels the memory returns.
- Applies a 1-2-1 / 2-4-2 / 1-2-1 smoothing kernel in a 2-stage pipeline.
- Issues one filtered-image write per window at the window centre; border pixels are never written.

Parameters:
- IMG_W, 256: image width in pixels, legal range 3..256.
- IMG_H, 256: image height in pixels, legal range 3..256.
- RD_LAT, 2: cycles from rd/address issue to the window pixels being valid at the inputs, legal range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- start  in  1  begin one full-image pass; sampled only in IDLE
- busy  out  1  high in SCAN and DRAIN
- done  out  1  one-cycle pulse after the final write
- rd  out  1  window read strobe to memory
- addr_row_r  out  8  window top-left row
- addr_col_r  out  8  window top-left column
- sw_pixel_1..sw_pixel_9  in  8 each  window pixels, row-major: 1..3 top row, 4..6 middle, 7..9 bottom
- wr  out  1  filtered-pixel write strobe
- addr_row_w  out  8  write row
- addr_col_w  out  8  write column
- cl_pixel  out  8  filtered pixel value

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst=0 sampled at a rising edge forces IDLE and drives all outputs to 0: busy, done, rd, wr, all addresses, cl_pixel.
  - Reset also clears every pipeline valid tag and the row/column counters, including mid-scan.
  - Writes in flight at reset are discarded and never issued.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: when start=1 at an edge, go to SCAN with row=0, col=0. start is ignored in every other state.
  - SCAN: one window per cycle. rd=1, addr_row_r=row, addr_col_r=col.
    - Column advances first: col goes 0..IMG_W-3, then wraps to 0 and row increments.
    - After issuing row=IMG_H-3, col=IMG_W-3, go to DRAIN.
  - DRAIN: runs exactly RD_LAT+2 cycles.
    - rd stays 1 for the first RD_LAT-1 cycles, with the address held at the final window, so the memory flushes the last window.
    - These extra reads carry no valid tag. rd=0 thereafter.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Window count: N = (IMG_H-2)*(IMG_W-2).
  - rd with a valid tag occurs in cycles c1..cN, where c1 is the cycle after start is sampled.
  - No gaps and no backpressure.
- Valid/address pipeline: a valid bit plus the (row, col) pair travel alongside each read. The tag pipeline is RD_LAT+2 deep.
- Filter arithmetic:
  - Stage 1, registered:
    - corner sum = p1+p3+p7+p9
    - edge sum = p2+p4+p6+p8
    - centre = p5
  - Stage 2, registered:
    - S = corner + 2*edge + 4*centre, computed in 12 bits (max 4080)
    - cl_pixel = (S+8)>>4
  - Rounding is round-half-up. The result is always at most 255, so there is no saturation logic.
- Write timing:
  - The window read in cycle ck produces wr=1 in cycle c(k+RD_LAT+2).
  - In that cycle addr_row_w = row+1 and addr_col_w = col+1.
  - wr is high for exactly N cycles, contiguous.
  - When wr=0, addr_row_w, addr_col_w and cl_pixel hold their last values.
- done falls in cycle c(N+RD_LAT+3).
- rd and wr may be high in the same cycle (pipeline overlap). This is legal: the memory's read and write ports are independent.

Test Plan:
- Constant image, every pixel 100, defaults; pulse start.
  - Expect exactly 254*254 = 64516 wr pulses, all cl_pixel = 100.
  - First write at (1,1), last at (254,254).
  - done one cycle after the last wr, busy low afterwards.
- Impulse test: pixel (10,10) = 255, all others 0.
  - Write to (10,10) gives cl_pixel = 64.
  - Writes to (10,11) and (11,10) give 32.
  - Write to (11,11) gives 16.
  - All other writes give 0.
- Small-frame timing, IMG_W=5, IMG_H=4, RD_LAT=2; start sampled at edge 0.
  - rd valid in cycles 1..6 with (row,col) = (0,0), (0,1), (0,2), (1,0), (1,1), (1,2).
  - rd also high in cycle 7 with the address held at (1,2).
  - wr in cycles 5..10 at (1,1), (1,2), (1,3), (2,1), (2,2), (2,3).
  - done in cycle 11.
- All-255 image -> every cl_pixel = 255, with no wrap or overflow.
- Assert rst=0 during SCAN, after 3 writes.
  - Next cycle: all outputs 0, state IDLE, no further wr.
  - A subsequent start restarts cleanly from (0,0).
- Pulse start again during SCAN and during DRAIN -> ignored: the write count and done timing are unchanged.
